pk_t1_unpack_ctrl: RTL and testbench

Sequencer for public-key decoding. It accepts the encoded public key as a byte stream: rho first, then K packed t1 polynomials of 320 bytes each. It latches rho and runs a streaming SimpleBitUnpack (b = 1023, 10-bit coefficients), emitting t1 coefficients one at a time over a valid/ready interface. It sits between the key-load byte source and t1 polynomial storage, and replaces a full-width combinational unpack with a small shifting bit buffer.

---
 rtl/pk_t1_unpack_ctrl.sv | 158 +++++++++++++++
 tb/tb_pk_t1_unpack_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pk_t1_unpack_ctrl.sv
// rtl/pk_t1_unpack_ctrl.sv - public-key decode sequencer: latches rho, streams 10-bit t1 coefficients
module pk_t1_unpack_ctrl #(
    parameter int K         = 4,
    parameter int COEF_W    = 10,
    parameter int RHO_BYTES = 32,
    localparam int PW       = (K > 1) ? $clog2(K) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*RHO_BYTES-1:0] rho,
    output logic                   rho_valid,
    output logic [COEF_W-1:0]      coef,
    output logic                   coef_valid,
    input  logic                   coef_ready,
    output logic [PW-1:0]          coef_poly,
    output logic [7:0]             coef_idx,
    output logic                   coef_last
);

    // Byte counter only has to reach RHO_BYTES-1.
    localparam int BW    = (RHO_BYTES > 1) ? $clog2(RHO_BYTES) : 1;
    // Worst case fill is 9 leftover bits + 8 new bits = 17, so 18 bits of buffer.
    localparam int BUF_W = 18;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RHO  = 2'd1,
        S_T1   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [BW-1:0]          bcnt_q;
    logic [BUF_W-1:0]       bitbuf_q, bitbuf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]          poly_q;
    logic [7:0]             idx_q;
    logic [8*RHO_BYTES-1:0] rho_q;
    logic                   rho_valid_q;
    logic                   done_q;

    logic in_hs;
    logic out_hs;
    logic last_coef;

    // Handshake qualifiers decoded from registered state; input and output
    // sides are mutually exclusive in T1 because they split on cnt >= 10.
    always_comb begin
        in_ready   = (state_q == S_RHO) ||
                     ((state_q == S_T1) && (cnt_q < CNT_W'(COEF_W)));
        coef_valid = (state_q == S_T1) && (cnt_q >= CNT_W'(COEF_W));
        in_hs      = in_valid & in_ready;
        out_hs     = coef_valid & coef_ready;
        last_coef  = (idx_q == 8'hFF) && (poly_q == PW'(K - 1));
    end

    // Bit buffer next state: append a byte above the current fill, or drop one coefficient.
    always_comb begin
        bitbuf_d = bitbuf_q;
        cnt_d    = cnt_q;
        if (state_q == S_T1) begin
            if (in_hs) begin
                bitbuf_d = bitbuf_q | (BUF_W'(in_byte) << cnt_q);
                cnt_d    = cnt_q + CNT_W'(8);
            end else if (out_hs) begin
                bitbuf_d = bitbuf_q >> COEF_W;
                cnt_d    = cnt_q - CNT_W'(COEF_W);
            end
        end
    end

    // Sequencer: rho capture, t1 unpack bookkeeping and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bcnt_q      <= '0;
            bitbuf_q    <= '0;
            cnt_q       <= '0;
            poly_q      <= '0;
            idx_q       <= '0;
            rho_q       <= '0;
            rho_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RHO;
                        bcnt_q  <= '0;
                    end
                end
                S_RHO: begin
                    if (in_hs) begin
                        for (int i = 0; i < RHO_BYTES; i++) begin
                            if (bcnt_q == BW'(i)) begin
                                rho_q[8*i +: 8] <= in_byte;
                            end
                        end
                        if (bcnt_q == BW'(RHO_BYTES - 1)) begin
                            rho_valid_q <= 1'b1;
                            bcnt_q      <= '0;
                            bitbuf_q    <= '0;
                            cnt_q       <= '0;
                            poly_q      <= '0;
                            idx_q       <= '0;
                            state_q     <= S_T1;
                        end else begin
                            bcnt_q <= bcnt_q + BW'(1);
                        end
                    end
                end
                S_T1: begin
                    bitbuf_q <= bitbuf_d;
                    cnt_q    <= cnt_d;
                    if (out_hs) begin
                        if (last_coef) begin
                            poly_q  <= '0;
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (idx_q == 8'hFF) begin
                            idx_q  <= '0;
                            poly_q <= poly_q + PW'(1);
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        rho_valid_q <= 1'b0;
                        bcnt_q      <= '0;
                        state_q     <= S_RHO;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_RHO) || (state_q == S_T1);
    assign done      = done_q;
    assign rho       = rho_q;
    assign rho_valid = rho_valid_q;
    assign coef      = bitbuf_q[COEF_W-1:0];
    assign coef_poly = poly_q;
    assign coef_idx  = idx_q;
    assign coef_last = coef_valid & last_coef;

endmodule

// File: tb/tb_pk_t1_unpack_ctrl.sv
// tb/tb_pk_t1_unpack_ctrl.sv - self-checking bench for pk_t1_unpack_ctrl
module tb_pk_t1_unpack_ctrl;

    localparam int K      = 4;
    localparam int NBYTES = 32 + 320 * K;
    localparam int NCOEF  = 256 * K;

    logic         clk, reset;
    logic         start, in_valid, coef_ready;
    logic [7:0]   in_byte;
    logic         busy, done, in_ready, rho_valid, coef_valid, coef_last;
    logic [255:0] rho;
    logic [9:0]   coef;
    logic [1:0]   coef_poly;
    logic [7:0]   coef_idx;

    logic         start1, in_valid1, coef_ready1;
    logic [7:0]   in_byte1;
    logic         busy1, done1, in_ready1, rho_valid1, coef_valid1, coef_last1;
    logic [255:0] rho1;
    logic [9:0]   coef1;
    logic [0:0]   coef_poly1;
    logic [7:0]   coef_idx1;

    pk_t1_unpack_ctrl #(.K(K)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .rho(rho), .rho_valid(rho_valid), .coef(coef), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .coef_poly(coef_poly), .coef_idx(coef_idx),
        .coef_last(coef_last)
    );

    pk_t1_unpack_ctrl #(.K(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .in_byte(in_byte1), .in_valid(in_valid1), .in_ready(in_ready1),
        .rho(rho1), .rho_valid(rho_valid1), .coef(coef1), .coef_valid(coef_valid1),
        .coef_ready(coef_ready1), .coef_poly(coef_poly1), .coef_idx(coef_idx1),
        .coef_last(coef_last1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rgap   = 0;
    bit chk_en = 0;

    // Reference model: stream bookkeeping in terms of bytes taken and coefficients handed out.
    int           m_phase = 0;   // 0 idle, 1 rho, 2 t1, 3 done
    int           m_nb = 0;
    int           m_nc = 0;
    logic [255:0] m_rho = '0;
    bit           m_rho_valid = 0;
    bit           m_done = 0;
    logic [7:0]   t1b [0:320*K-1];
    bit           bnd_flag = 0;
    bit           prev_stall = 0;
    logic [9:0]   prev_coef = '0;

    int           cap[$];
    int           done_cnt = 0;
    int           last_cnt = 0;
    int           non3ff = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_coef(input int n);
        int bitpos, b, off, w;
        bitpos = 10 * n;
        b      = bitpos / 8;
        off    = bitpos % 8;
        w      = int'(t1b[b]) | (int'(t1b[b+1]) << 8);
        return (w >> off) & 1023;
    endfunction

    function automatic logic [7:0] gen(input int mode, input int i);
        int j;
        j = i - 32;
        if (i < 32) return 8'(i);
        case (mode)
            0:       return 8'hFF;
            1:       return (j % 5 == 0) ? 8'h01 : 8'h00;
            2:       return (j % 5 == 1) ? 8'h04 : 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    int  t1n, avail;
    bit  e_inr, e_cv;

    // Compare DUT against the model every cycle, then advance the model by what the next edge will do.
    always @(negedge clk) begin
        t1n   = (m_nb > 32) ? m_nb - 32 : 0;
        avail = 8 * t1n - 10 * m_nc;
        e_inr = (m_phase == 1) || (m_phase == 2 && avail < 10);
        e_cv  = (m_phase == 2) && (avail >= 10);
        if (chk_en) begin
            check("busy", busy, (m_phase == 1 || m_phase == 2));
            check("in_ready", in_ready, e_inr);
            check("coef_valid", coef_valid, e_cv);
            check("done", done, m_done);
            check("rho_valid", rho_valid, m_rho_valid);
            if (m_rho_valid) check("rho", rho, m_rho);
            if (e_cv) begin
                check("coef", coef, exp_coef(m_nc));
                check("coef_poly", coef_poly, m_nc / 256);
                check("coef_idx", coef_idx, m_nc % 256);
                check("coef_last", coef_last, (m_nc == NCOEF - 1));
                if (prev_stall) check("coef_stable", coef, prev_coef);
            end
            if (bnd_flag) check("poly_boundary_empty", {coef_valid, in_ready}, 2'b01);
        end
        bnd_flag   = 0;
        prev_stall = coef_valid && !coef_ready;
        prev_coef  = coef;
        if (done) done_cnt++;
        m_done = 0;
        if (reset) begin
            m_phase = 0; m_nb = 0; m_nc = 0; m_rho = '0; m_rho_valid = 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_nb = 0; m_nc = 0; end
                1: if (in_valid && e_inr) begin
                       m_rho[8*m_nb +: 8] = in_byte;
                       m_nb++;
                       if (m_nb == 32) begin m_phase = 2; m_rho_valid = 1; end
                   end
                2: if (in_valid && e_inr) begin
                       t1b[t1n] = in_byte;
                       m_nb++;
                   end else if (coef_ready && e_cv) begin
                       cap.push_back(int'(coef));
                       if (coef != 10'h3FF) non3ff++;
                       if (coef_last) last_cnt++;
                       m_nc++;
                       if (m_nc == NCOEF) begin m_phase = 3; m_done = 1; end
                       else if (m_nc % 256 == 0) bnd_flag = 1;
                   end
                default: if (start) begin m_phase = 1; m_rho_valid = 0; m_nb = 0; m_nc = 0; end
            endcase
        end
    end

    initial begin
        coef_ready = 0;
        forever begin
            @(posedge clk); #1;
            coef_ready = ($urandom_range(99) >= rgap);
        end
    end

    task automatic clear_stats();
        cap.delete(); done_cnt = 0; last_cnt = 0; non3ff = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic feed(input int mode, input int vgap, input bit inject, input bit abort);
        int i, guard;
        bit stop;
        logic [7:0] cur;
        i = 0; guard = 0; stop = 0;
        cur = gen(mode, 0);
        while (i < NBYTES && guard < 20000 && !stop) begin
            in_byte  = cur;
            in_valid = ($urandom_range(99) >= vgap);
            start    = inject && (i == 10 || i == 200);
            @(negedge clk);
            if (abort && coef_valid && coef_poly == 2'd2 && coef_idx == 8'd100) stop = 1;
            if (in_valid && in_ready) begin i++; cur = gen(mode, i); end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 0; start = 0;
        if (guard >= 20000) begin
            checks++; errors++;
            $display("FAIL feed_timeout: got %0d bytes expected %0d", i, NBYTES);
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done_cnt == 0 && guard < 20000) begin
            @(posedge clk); guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (guard >= 20000) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected a pulse");
        end
    endtask

    task automatic check_rst_outputs();
        @(negedge clk);
        check("rst_busy", busy, 0);        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0); check("rst_rho_valid", rho_valid, 0);
        check("rst_rho", rho, 0);          check("rst_coef", coef, 0);
        check("rst_coef_valid", coef_valid, 0); check("rst_coef_poly", coef_poly, 0);
        check("rst_coef_idx", coef_idx, 0); check("rst_coef_last", coef_last, 0);
    endtask

    task automatic run_decode(input int mode, input int vgap, input bit inject);
        clear_stats();
        pulse_start();
        feed(mode, vgap, inject, 0);
        wait_done();
        check("done_pulses", done_cnt, 1);
        check("coef_count", cap.size(), NCOEF);
        check("last_count", last_cnt, 1);
    endtask

    initial begin
        int nb, nc, d1, extra;
        clk = 0; reset = 1; start = 0; in_valid = 0; in_byte = 0;
        start1 = 0; in_valid1 = 0; in_byte1 = 0; coef_ready1 = 0;
        repeat (3) @(posedge clk);
        #1; chk_en = 1; reset = 0;
        check_rst_outputs();
        @(posedge clk); #1;

        // All-ones polynomials with incrementing rho.
        run_decode(0, 0, 0);
        check("t1_all_3ff", non3ff, 0);
        check("rho_byte0", rho[7:0], 8'h00);
        check("rho_byte31", rho[255:248], 8'h1F);
        in_valid = 1; in_byte = 8'hAA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("in_ready_after_done", in_ready, 0);
        end
        @(posedge clk); #1; in_valid = 0;

        // Sparse single-bit patterns, including a coefficient straddling a byte boundary.
        clear_stats();
        pulse_start();
        @(negedge clk);
        check("rho_valid_cleared_on_restart", rho_valid, 0);
        @(posedge clk); #1;
        feed(1, 0, 0, 0);
        wait_done();
        for (int k = 0; k < 8; k++) check("pattern_01", cap[k], (k % 4 == 0) ? 1 : 0);
        run_decode(2, 0, 0);
        for (int k = 0; k < 8; k++) check("pattern_0004", cap[k], (k % 4 == 1) ? 1 : 0);

        // Random data with gaps on both sides and stray start pulses while busy.
        rgap = 30;
        run_decode(3, 30, 1);

        // Reset at polynomial 2 index 100, then a clean decode from IDLE.
        rgap = 20;
        clear_stats();
        pulse_start();
        feed(3, 20, 0, 1);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        check_rst_outputs();
        check("rst_no_done", done_cnt, 0);
        rgap = 0;
        @(posedge clk); #1;
        run_decode(3, 0, 0);

        // K=1 instance: 352 bytes, 256 coefficients, single-bit poly index held at 0.
        nb = 0; nc = 0; d1 = 0; extra = 0;
        @(posedge clk); #1 start1 = 1;
        @(posedge clk); #1 start1 = 0; in_valid1 = 1; coef_ready1 = 1;
        in_byte1 = gen(1, 0);
        for (int c = 0; c < 3000 && !(d1 > 0 && extra >= 4); c++) begin
            @(negedge clk);
            if (in_valid1 && in_ready1) nb++;
            if (coef_valid1) begin
                check("k1_coef", coef1, (nc % 4 == 0) ? 1 : 0);
                check("k1_poly", coef_poly1, 0);
                check("k1_idx", coef_idx1, nc % 256);
                check("k1_last", coef_last1, (nc == 255));
                nc++;
            end
            if (done1) d1++;
            if (d1 > 0) extra++;
            @(posedge clk); #1;
            in_byte1 = gen(1, nb);
        end
        in_valid1 = 0;
        check("k1_bytes", nb, 352);
        check("k1_coefs", nc, 256);
        check("k1_done", d1, 1);
        check("k1_rho_hi", rho1[255:248], 8'h1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
